// File: rtl/dr_seq_pkg.sv
// rtl/dr_seq_pkg.sv - shared types and constants for the DR load sequencer
package dr_seq_pkg;

    localparam int DR_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        LOAD
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_INSM,
        SRC_DM,
        SRC_BUS
    } src_t;

endpackage

// File: rtl/dr_load_sequencer_if.sv
// rtl/dr_load_sequencer_if.sv - request/ack, memory read and DR write-enable bundle
interface dr_load_sequencer_if;

    logic fetch_req;
    logic load_req;
    logic bus_req;
    logic fetch_ack;
    logic load_ack;
    logic bus_ack;
    logic insm_rd;
    logic insm_rdy;
    logic dm_rd;
    logic dm_rdy;
    logic dr_wen_insm;
    logic dr_wen_dm;
    logic dr_wen_bus;
    logic busy;
    logic err_timeout;

    // master: control unit plus memories; slave: the sequencer
    modport master (
        output fetch_req, load_req, bus_req, insm_rdy, dm_rdy,
        input  fetch_ack, load_ack, bus_ack, insm_rd, dm_rd,
        input  dr_wen_insm, dr_wen_dm, dr_wen_bus, busy, err_timeout
    );

    modport slave (
        input  fetch_req, load_req, bus_req, insm_rdy, dm_rdy,
        output fetch_ack, load_ack, bus_ack, insm_rd, dm_rd,
        output dr_wen_insm, dr_wen_dm, dr_wen_bus, busy, err_timeout
    );

endinterface

// File: rtl/dr_seq_arb.sv
// rtl/dr_seq_arb.sv - fixed-priority fetch > load > bus grant
module dr_seq_arb
    import dr_seq_pkg::*;
(
    input  logic fetch_req,
    input  logic load_req,
    input  logic bus_req,
    output src_t grant
);

    // Same ordering as the DR's own mux priority, so the two can never disagree
    always_comb begin
        grant = SRC_NONE;
        if (fetch_req) begin
            grant = SRC_INSM;
        end else if (load_req) begin
            grant = SRC_DM;
        end else if (bus_req) begin
            grant = SRC_BUS;
        end
    end

endmodule

// File: rtl/dr_load_sequencer.sv
// rtl/dr_load_sequencer.sv - DR load arbiter and memory read handshake FSM
// Optional read watchdog enabled by defining DR_SEQ_TIMEOUT_EN.
module dr_load_sequencer
    import dr_seq_pkg::*;
#(
    parameter int reg_width = DR_WIDTH,
    parameter int TIMEOUT   = 15
) (
    input  logic clk,
    input  logic reset,
    dr_load_sequencer_if.slave drs
);

    if (reg_width != DR_WIDTH || TIMEOUT < 1) begin : g_param_chk
        $error("dr_load_sequencer: reg_width must equal DR_WIDTH and TIMEOUT must be >= 1");
    end

    state_t state_q;
    src_t   src_q;
    src_t   grant;
    logic   rdy_sel;

    dr_seq_arb u_arb (
        .fetch_req (drs.fetch_req),
        .load_req  (drs.load_req),
        .bus_req   (drs.bus_req),
        .grant     (grant)
    );

    // Only the latched memory's ready can advance RD; the other one is ignored
    always_comb begin
        rdy_sel = 1'b0;
        if (src_q == SRC_INSM) begin
            rdy_sel = drs.insm_rdy;
        end else if (src_q == SRC_DM) begin
            rdy_sel = drs.dm_rdy;
        end
    end

`ifdef DR_SEQ_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic          err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= SRC_NONE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant == SRC_BUS) begin
                        state_q <= LOAD;
                        src_q   <= SRC_BUS;
                    end else if (grant != SRC_NONE) begin
                        state_q <= RD;
                        src_q   <= grant;
                        cnt_q   <= '0;
                    end
                end
                RD: begin
                    if (rdy_sel) begin
                        state_q <= LOAD;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // Abort: no write, no ack; requester sees err_timeout instead
                        state_q <= IDLE;
                        src_q   <= SRC_NONE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= IDLE;
                    src_q   <= SRC_NONE;
                end
                default: begin
                    state_q <= IDLE;
                    src_q   <= SRC_NONE;
                end
            endcase
        end
    end

    assign drs.err_timeout = err_q;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            src_q   <= SRC_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant == SRC_BUS) begin
                        state_q <= LOAD;
                        src_q   <= SRC_BUS;
                    end else if (grant != SRC_NONE) begin
                        state_q <= RD;
                        src_q   <= grant;
                    end
                end
                RD: begin
                    if (rdy_sel) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= IDLE;
                    src_q   <= SRC_NONE;
                end
                default: begin
                    state_q <= IDLE;
                    src_q   <= SRC_NONE;
                end
            endcase
        end
    end

    assign drs.err_timeout = 1'b0;
`endif

    // Moore decode of state and latched source; one-hot by construction
    assign drs.insm_rd     = (state_q == RD)   && (src_q == SRC_INSM);
    assign drs.dm_rd       = (state_q == RD)   && (src_q == SRC_DM);
    assign drs.dr_wen_insm = (state_q == LOAD) && (src_q == SRC_INSM);
    assign drs.dr_wen_dm   = (state_q == LOAD) && (src_q == SRC_DM);
    assign drs.dr_wen_bus  = (state_q == LOAD) && (src_q == SRC_BUS);
    assign drs.fetch_ack   = drs.dr_wen_insm;
    assign drs.load_ack    = drs.dr_wen_dm;
    assign drs.bus_ack     = drs.dr_wen_bus;
    assign drs.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dr_load_sequencer.sv
// tb/tb_dr_load_sequencer.sv - scoreboard bench with randomized requests and memory latency
module tb_dr_load_sequencer;
    import dr_seq_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dr_load_sequencer_if dif ();

    dr_load_sequencer #(.reg_width(DR_WIDTH), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .drs   (dif)
    );

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    src_t exp_q[$];

    bit   rsp_hold = 1'b0;
    int   rdy_cycle = -10;
    int   exp_len = 0;
    int   cnt_i = 0, dly_i = 0, cnt_d = 0, dly_d = 0;

    int   rd_run = 0;
    int   rd_len_last = 0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [2:0] onehot(input src_t s);
        case (s)
            SRC_INSM: return 3'b100;
            SRC_DM:   return 3'b010;
            SRC_BUS:  return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

    // Memory model: ready after a random wait, plus stray ready pulses on the idle memory
    always @(negedge clk) begin
        dif.insm_rdy = 1'b0;
        dif.dm_rdy   = 1'b0;
        if (dif.insm_rd) begin
            if (!rsp_hold && cnt_i >= dly_i) begin
                dif.insm_rdy = 1'b1;
                rdy_cycle = cycle;
                exp_len = cnt_i + 1;
            end
            cnt_i++;
            if ($urandom_range(0, 2) == 0) dif.dm_rdy = 1'b1;
        end else begin
            cnt_i = 0;
            dly_i = $urandom_range(0, 5);
        end
        if (dif.dm_rd) begin
            if (!rsp_hold && cnt_d >= dly_d) begin
                dif.dm_rdy = 1'b1;
                rdy_cycle = cycle;
                exp_len = cnt_d + 1;
            end
            cnt_d++;
            if ($urandom_range(0, 2) == 0) dif.insm_rdy = 1'b1;
        end else begin
            cnt_d = 0;
            dly_d = $urandom_range(0, 5);
        end
    end

    // Monitor: every DR write is popped against the scoreboard
    always @(negedge clk) begin
        logic [2:0] wen;
        logic [2:0] ack;
        src_t       e;
        wen = {dif.dr_wen_insm, dif.dr_wen_dm, dif.dr_wen_bus};
        ack = {dif.fetch_ack, dif.load_ack, dif.bus_ack};
        if (dif.insm_rd || dif.dm_rd) begin
            rd_run++;
        end else begin
            if (rd_run != 0) rd_len_last = rd_run;
            rd_run = 0;
        end
        if (wen != 3'b000) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wen", int'(wen), 0);
            end else begin
                e = exp_q.pop_front();
                chk("wen_src", int'(wen), int'(onehot(e)));
                chk("ack_src", int'(ack), int'(onehot(e)));
                chk("busy_in_load", int'(dif.busy), 1);
                if (e == SRC_BUS) begin
                    chk("bus_from_idle", int'(prev_busy), 0);
                end else begin
                    chk("mem_rdy_to_wen", rdy_cycle, cycle - 1);
                    chk("rd_strobe_len", rd_len_last, exp_len);
                end
            end
        end else if (ack != 3'b000) begin
            chk("ack_without_wen", int'(ack), 0);
        end
        prev_busy = dif.busy;
    end

    task automatic drain_acks();
        int i;
        for (i = 0; i < 300 && (dif.fetch_req || dif.load_req || dif.bus_req); i++) begin
            @(negedge clk);
            if (dif.fetch_ack) dif.fetch_req = 1'b0;
            if (dif.load_ack)  dif.load_req  = 1'b0;
            if (dif.bus_ack)   dif.bus_req   = 1'b0;
        end
        if (dif.fetch_req || dif.load_req || dif.bus_req) begin
            chk("txn_timeout", int'({dif.fetch_req, dif.load_req, dif.bus_req}), 0);
            dif.fetch_req = 1'b0;
            dif.load_req  = 1'b0;
            dif.bus_req   = 1'b0;
        end
    endtask

    // Requests held until serviced are always served in priority order
    task automatic run_txn(input logic [2:0] m);
        @(negedge clk);
        {dif.fetch_req, dif.load_req, dif.bus_req} = m;
        if (m[2]) exp_q.push_back(SRC_INSM);
        if (m[1]) exp_q.push_back(SRC_DM);
        if (m[0]) exp_q.push_back(SRC_BUS);
        drain_acks();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        dif.fetch_req = 1'b0;
        dif.load_req  = 1'b0;
        dif.bus_req   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({dif.fetch_ack, dif.load_ack, dif.bus_ack, dif.insm_rd, dif.dm_rd,
            dif.dr_wen_insm, dif.dr_wen_dm, dif.dr_wen_bus, dif.busy, dif.err_timeout}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_not_busy", int'(dif.busy), 0);

        run_txn(3'b001);
        run_txn(3'b010);
        run_txn(3'b111);
        run_txn(3'b100);
        for (int k = 0; k < 40; k++) begin
            run_txn(3'($urandom_range(1, 7)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a fetch read abandons it
        rsp_hold = 1'b1;
        @(negedge clk);
        dif.fetch_req = 1'b1;
        for (int i = 0; i < 10 && !dif.insm_rd; i++) @(negedge clk);
        chk("fetch_rd_started", int'(dif.insm_rd), 1);
        #2 reset = 1'b0;
        #1 chk("async_reset_outputs", int'({dif.fetch_ack, dif.insm_rd, dif.dr_wen_insm, dif.busy}), 0);
        @(negedge clk);
        dif.fetch_req = 1'b0;
        reset = 1'b1;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (dif.fetch_ack || dif.busy) n++;
        end
        chk("no_ack_after_reset", n, 0);
        rsp_hold = 1'b0;

        // DM never ready
        rsp_hold = 1'b1;
        @(negedge clk);
        dif.load_req = 1'b1;
        for (int i = 0; i < 10 && !dif.dm_rd; i++) @(negedge clk);
        chk("dm_rd_started", int'(dif.dm_rd), 1);
        n = 0;
`ifdef DR_SEQ_TIMEOUT_EN
        for (int i = 0; i < 200 && dif.dm_rd; i++) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_rd_len", n, TMO);
        chk("err_timeout_pulse", int'(dif.err_timeout), 1);
        chk("timeout_no_ack", int'({dif.load_ack, dif.dr_wen_dm}), 0);
        dif.load_req = 1'b0;
        @(negedge clk);
        chk("err_timeout_single", int'(dif.err_timeout), 0);
        rsp_hold = 1'b0;
`else
        repeat (100) begin
            if (dif.dm_rd) n++;
            @(negedge clk);
        end
        chk("dm_rd_held_100", n, 100);
        chk("no_err_timeout", int'(dif.err_timeout), 0);
        exp_q.push_back(SRC_DM);
        rsp_hold = 1'b0;
        drain_acks();
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
